// File: rtl/activation_backward_float_16.sv
// fp16 helper package: shared round-to-nearest-even packing for the arithmetic operators.
// Combinational only.
// No handshake; pure functions.
package fp16_pkg;
  // Value of m is 1.m[30:0] x 2^(e-15) once m[31] is set; m[20] is guard, m[19:0] sticky.
  function automatic logic [15:0] round_pack(input logic s, input int e_in, input logic [31:0] m_in);
    int          e;
    logic [31:0] m;
    logic        st;
    logic        inc;
    logic [14:0] mag;
    e  = e_in;
    m  = m_in;
    st = 1'b0;
    // Denormalise tiny results up to the minimum exponent, collecting lost bits.
    for (int i = 0; i < 32; i++) begin
      if (e < 1) begin
        st = st | m[0];
        m  = m >> 1;
        e  = e + 1;
      end
    end
    // Normalise left until the hidden bit sits in m[31] or the exponent bottoms out.
    for (int i = 0; i < 32; i++) begin
      if (!m[31] && e > 1) begin
        m = m << 1;
        e = e - 1;
      end
    end
    m[0] = m[0] | st;
    if (!m[31]) e = 0;
    if (e >= 31) return {s, 5'h1f, 10'h000};
    inc = m[20] & ((|m[19:0]) | m[21]);
    // A rounding carry ripples into the exponent, including max-normal to infinity.
    mag = {e[4:0], m[30:21]} + {14'h0000, inc};
    return {s, mag};
  endfunction
endpackage

// fp16 ordered greater-than: gt = a > b, false when either operand is NaN, +0 == -0.
// Combinational, zero latency.
// No handshake.
module floating_point_compare (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt
);
  logic nan_a, nan_b;
  // Sign-magnitude ordering with NaN and signed-zero special cases.
  always_comb begin
    nan_a = (&a[14:10]) && (|a[9:0]);
    nan_b = (&b[14:10]) && (|b[9:0]);
    gt    = 1'b0;
    if (nan_a || nan_b || (a[14:0] == 15'h0 && b[14:0] == 15'h0)) gt = 1'b0;
    else if (a[15] != b[15]) gt = !a[15];
    else if (a[15]) gt = a[14:0] < b[14:0];
    else gt = a[14:0] > b[14:0];
  end
endmodule

// fp16 subtract: result = a - b, round-to-nearest-even, subnormals supported.
// Combinational, zero latency.
// No handshake.
module floating_point_subtract (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);
  logic [15:0] bn, x, y;
  logic [4:0]  ex, ey, d;
  logic [31:0] xm, ym_full, ym, sum;
  logic        st, nan_a, nan_b, inf_a, inf_b;
  // Add a to -b: order by magnitude, align the smaller operand with sticky, add/sub, pack.
  always_comb begin
    bn      = {~b[15], b[14:0]};
    nan_a   = (&a[14:10]) && (|a[9:0]);
    nan_b   = (&bn[14:10]) && (|bn[9:0]);
    inf_a   = (&a[14:10]) && !(|a[9:0]);
    inf_b   = (&bn[14:10]) && !(|bn[9:0]);
    if (bn[14:0] > a[14:0]) begin
      x = bn;
      y = a;
    end else begin
      x = a;
      y = bn;
    end
    ex      = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey      = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    d       = ex - ey;
    xm      = {1'b0, |x[14:10], x[9:0], 20'h00000};
    ym_full = {1'b0, |y[14:10], y[9:0], 20'h00000};
    st      = |(ym_full & ((32'd1 << d) - 32'd1));
    ym      = (ym_full >> d) | {31'h0, st};
    sum     = (x[15] == y[15]) ? (xm + ym) : (xm - ym);
    if (nan_a || nan_b || (inf_a && inf_b && (a[15] != bn[15]))) result = 16'h7E00;
    else if (inf_a) result = a;
    else if (inf_b) result = bn;
    else if (sum == 32'h0) result = {x[15] & y[15], 15'h0000};
    else result = fp16_pkg::round_pack(x[15], int'(ex) + 1, sum);
  end
endmodule

// fp16 multiply: result = a * b, round-to-nearest-even, subnormals supported.
// Combinational, zero latency.
// No handshake.
module floating_point_multiply (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);
  logic [4:0]  ea, eb;
  logic [21:0] p;
  logic        s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  // Integer mantissa product, then a shared round/pack; special operands short-circuit.
  always_comb begin
    s      = a[15] ^ b[15];
    nan_a  = (&a[14:10]) && (|a[9:0]);
    nan_b  = (&b[14:10]) && (|b[9:0]);
    inf_a  = (&a[14:10]) && !(|a[9:0]);
    inf_b  = (&b[14:10]) && !(|b[9:0]);
    zero_a = (a[14:0] == 15'h0);
    zero_b = (b[14:0] == 15'h0);
    ea     = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb     = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    p      = 22'({|a[14:10], a[9:0]}) * 22'({|b[14:10], b[9:0]});
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) result = 16'h7E00;
    else if (inf_a || inf_b) result = {s, 15'h7C00};
    else result = fp16_pkg::round_pack(s, int'(ea) + int'(eb) - 14, {p, 10'h000});
  end
endmodule

// Activation backward pass: grad_out = g * f'(x) in terms of y, one sample at a time.
// Latency accept-to-out_valid: NONE 1, ReLU 2, sigmoid/tanh 4 cycles.
// in_ready only in IDLE; no output backpressure, out_valid is a single-cycle pulse.
module activation_backward_float_16 #(
  parameter int DATA_WIDTH = 16,
  parameter int TYPE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TYPE_WIDTH-1:0] type_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] act_data,
  input  logic [DATA_WIDTH-1:0] grad_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] grad_out
);
  typedef enum logic [2:0] {IDLE, STEP1, STEP2, STEP3, DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_RELU, OP_SIG, OP_TANH} op_t;

  localparam logic [15:0] FP_ONE = 16'h3C00;

  state_t      state, next_state;
  op_t         op_in, op_q;
  logic [15:0] y_q, g_q, t_q;
  logic        gt_q, cmp_gt, accept;
  logic [15:0] mul_a, mul_b, mul_res, sub_b, sub_res;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  // Codes above 3 fall back to pass-through.
  assign op_in    = (type_sel[TYPE_WIDTH-1:2] == '0) ? op_t'(type_sel[1:0]) : OP_NONE;

  floating_point_compare  u_cmp (.a(y_q), .b(16'h0000), .gt(cmp_gt));
  floating_point_subtract u_sub (.a(FP_ONE), .b(sub_b), .result(sub_res));
  floating_point_multiply u_mul (.a(mul_a), .b(mul_b), .result(mul_res));

  // Operand steering for the shared multiplier and subtractor, keyed by step only:
  // STEP1 y*y (tanh) and 1-y (sigmoid), STEP2 y*t (sigmoid) and 1-t (tanh), STEP3 t*g.
  always_comb begin
    mul_a = (state == STEP3) ? t_q : y_q;
    mul_b = (state == STEP3) ? g_q : ((state == STEP1) ? y_q : t_q);
    sub_b = (state == STEP1) ? y_q : t_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: pass-through jumps straight to DONE, ReLU needs one compare step.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = (op_in == OP_NONE) ? DONE : STEP1;
      STEP1:   next_state = (op_q == OP_RELU) ? DONE : STEP2;
      STEP2:   next_state = STEP3;
      STEP3:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latch at accept, one registered arithmetic result per step, output at DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= 16'h0000;
      g_q       <= 16'h0000;
      t_q       <= 16'h0000;
      op_q      <= OP_NONE;
      gt_q      <= 1'b0;
      out_valid <= 1'b0;
      grad_out  <= 16'h0000;
    end else begin
      out_valid <= (state == DONE);
      if (accept) begin
        y_q  <= act_data;
        g_q  <= grad_data;
        op_q <= op_in;
      end
      case (state)
        STEP1: begin
          if (op_q == OP_RELU)     gt_q <= cmp_gt;
          else if (op_q == OP_SIG) t_q  <= sub_res;
          else                     t_q  <= mul_res;
        end
        STEP2: t_q <= (op_q == OP_SIG) ? mul_res : sub_res;
        STEP3: t_q <= mul_res;
        DONE: begin
          case (op_q)
            OP_NONE: grad_out <= g_q;
            OP_RELU: grad_out <= gt_q ? g_q : 16'h0000;
            default: grad_out <= t_q;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_activation_backward_float_16.sv
// Directed bench for activation_backward_float_16: latency, in_ready window and results.
// Expected values are hand-computed fp16 constants.
// Inputs are scrambled while busy to show they are latched at accept.
module tb_activation_backward_float_16;
  logic        clk;
  logic        rst_n;
  logic [3:0]  type_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] act_data;
  logic [15:0] grad_data;
  logic        out_valid;
  logic [15:0] grad_out;

  int checks = 0;
  int errors = 0;

  activation_backward_float_16 #(.DATA_WIDTH(16), .TYPE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .type_sel(type_sel), .in_valid(in_valid), .in_ready(in_ready),
    .act_data(act_data), .grad_data(grad_data), .out_valid(out_valid), .grad_out(grad_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1ns after a rising edge with the DUT idle; returns 1ns after the edge ending the pulse.
  task automatic run_op(input string tag, input logic [3:0] t, input logic [15:0] y,
                        input logic [15:0] g, input logic [15:0] exp, input int exp_lat);
    int lat;
    int low;
    logic [15:0] held;
    type_sel  = t;
    act_data  = y;
    grad_data = g;
    in_valid  = 1'b1;
    check({tag, " ready_before"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    type_sel  = 4'd2;
    act_data  = 16'h5555;
    grad_data = 16'hAAAA;
    lat = 0;
    low = 0;
    while (!out_valid && lat < 20) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " ready_low_cycles"}, 32'(low), 32'(exp_lat));
    check({tag, " ready_at_pulse"}, 32'(in_ready), 32'd1);
    check({tag, " grad_out"}, 32'(grad_out), 32'(exp));
    held = grad_out;
    @(posedge clk); #1;
    check({tag, " pulse_end"}, 32'(out_valid), 32'd0);
    check({tag, " grad_hold"}, 32'(grad_out), 32'(exp));
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    type_sel  = 4'd0;
    act_data  = 16'h0000;
    grad_data = 16'h0000;
    #3;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset grad_out", 32'(grad_out), 32'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("none",        4'd0, 16'h4200, 16'hC000, 16'hC000, 1);
    run_op("relu pos",    4'd1, 16'h3C00, 16'h4000, 16'h4000, 2);
    run_op("relu neg",    4'd1, 16'hBC00, 16'h4000, 16'h0000, 2);
    run_op("none code5",  4'd5, 16'h0000, 16'h3555, 16'h3555, 1);
    run_op("relu pzero",  4'd1, 16'h0000, 16'h4000, 16'h0000, 2);
    run_op("none g1234",  4'd0, 16'h0000, 16'h1234, 16'h1234, 1);
    run_op("relu nzero",  4'd1, 16'h8000, 16'h4000, 16'h0000, 2);
    run_op("relu small",  4'd1, 16'h0001, 16'h4000, 16'h4000, 2);
    run_op("relu nan",    4'd1, 16'h7E00, 16'h4000, 16'h0000, 2);
    // 0.5*(1-0.5)*1 = 0.25
    run_op("sig half",    4'd2, 16'h3800, 16'h3C00, 16'h3400, 4);
    // 0.75*(1-0.75)*4 = 0.75
    run_op("sig 0.75",    4'd2, 16'h3A00, 16'h4400, 16'h3A00, 4);
    // (1-0.25)*2 = 1.5
    run_op("tanh half",   4'd3, 16'h3800, 16'h4000, 16'h3E00, 4);
    // (1-1)*2 = +0
    run_op("tanh one",    4'd3, 16'h3C00, 16'h4000, 16'h0000, 4);

    // Back-to-back: in_valid held high, second sample presented while the first is busy.
    type_sel  = 4'd3;
    act_data  = 16'h3800;
    grad_data = 16'h4000;
    in_valid  = 1'b1;
    check("b2b ready_first", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    act_data  = 16'h3400;
    grad_data = 16'h3C00;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b first latency", 32'(lat), 32'd4);
    check("b2b first grad_out", 32'(grad_out), 32'h3E00);
    check("b2b ready_at_pulse", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    type_sel  = 4'd1;
    act_data  = 16'hFFFF;
    grad_data = 16'h7C00;
    check("b2b second accepted", 32'(in_ready), 32'd0);
    // Second pulse arrives four cycles after its accept edge, which is one edge after the first pulse.
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // (1-0.0625)*1 = 0.9375
    check("b2b pulse spacing", 32'(lat), 32'd5);
    check("b2b second grad_out", 32'(grad_out), 32'h3B80);
    @(posedge clk); #1;
    check("b2b pulse_end", 32'(out_valid), 32'd0);

    // Reset two cycles into a sigmoid operation aborts it.
    type_sel  = 4'd2;
    act_data  = 16'h3800;
    grad_data = 16'h3C00;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort grad_out", 32'(grad_out), 32'h0000);
    check("abort in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort no pulse", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    run_op("relu after reset", 4'd1, 16'h3C00, 16'h4000, 16'h4000, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
